// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register
//
// Generic D-type storage / pipeline stage. Captures `d` on every rising edge
// of `clk` and holds it on `q` until the next edge. An asynchronous,
// active-high `reset` forces `q` to RESET_VALUE immediately and keeps it
// there while asserted. Reset wins over a coincident clock edge.
//
// `q` comes straight from flops, so there is no combinational path from `d`.
// Reset release is not synchronized here; the integrator must provide a
// release synchronizer if `reset` is asynchronous to `clk`.
// ---------------------------------------------------------------------------
module register #(
  parameter int unsigned          WIDTH       = 7,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage flops: async load of RESET_VALUE, otherwise capture d each edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, and reset sits in the sensitivity list
  // so it acts without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_register.sv
// ---------------------------------------------------------------------------
// tb_register
//
// Self-checking bench for `register`. Two instances share clock and reset:
// the default 7-bit one and a 12-bit one with RESET_VALUE = 12'hA5A.
// A behavioural model tracks "the value most recently stored": the word that
// was on d at the last edge without reset, or the reset value whenever reset
// is (or becomes) high. A compare process checks both instances against the
// model on every falling edge; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_register;

  localparam int unsigned W7  = 7;
  localparam int unsigned W12 = 12;
  localparam logic [W12-1:0] RV12 = 12'hA5A;

  logic           clk;
  logic           reset;
  logic [W7-1:0]  d7;
  logic [W7-1:0]  q7;
  logic [W12-1:0] d12;
  logic [W12-1:0] q12;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [W7-1:0]  exp7;
  logic [W12-1:0] exp12;
  bit             model_valid = 1'b0;

  register dut7 (
    .clk   (clk),
    .reset (reset),
    .d     (d7),
    .q     (q7)
  );

  register #(
    .WIDTH       (W12),
    .RESET_VALUE (RV12)
  ) dut12 (
    .clk   (clk),
    .reset (reset),
    .d     (d12),
    .q     (q12)
  );

  // 20 ns clock, starting low.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [W12-1:0] actual,
                       input logic [W12-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a clock edge stores d unless reset is high; a reset rise stores
  // the reset value at once. If a reset rise coincides with an edge, both
  // handlers converge on the reset value whatever their order.
  initial begin
    forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        exp7  = '0;
        exp12 = RV12;
      end else begin
        exp7  = d7;
        exp12 = d12;
      end
      model_valid = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge reset);
      exp7  = '0;
      exp12 = RV12;
    end
  end

  // Continuous comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("model_q7",  {5'b0, q7}, {5'b0, exp7});
        check("model_q12", q12, exp12);
      end
    end
  end

  // Move to 2 ns after the next rising edge.
  task automatic next_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    d7    = '0;
    d12   = '0;

    // Reset clear: q forced asynchronously, no edge yet.
    #1;
    check("reset_async_q7",  {5'b0, q7}, 12'h000);
    check("reset_async_q12", q12, 12'hA5A);
    next_edge();
    check("reset_hold_q7", {5'b0, q7}, 12'h000);
    next_edge();

    // Basic capture: release reset, q keeps reset value until the next edge.
    reset = 1'b0;
    d7    = 7'h07;
    d12   = 12'hFFF;
    @(negedge clk);
    check("before_edge_q7",  {5'b0, q7}, 12'h000);
    check("before_edge_q12", q12, 12'hA5A);
    next_edge();
    check("capture_q7",  {5'b0, q7}, 12'h007);
    check("capture_q12", q12, 12'hFFF);

    // Per-cycle update with glitches on d between edges.
    d7 = 7'h55;
    next_edge();
    check("seq_55", {5'b0, q7}, 12'h055);
    #3 d7 = 7'h11;
    #4 d7 = 7'h66;
    @(negedge clk);
    check("glitch_ignored", {5'b0, q7}, 12'h055);
    d7 = 7'h2A;
    next_edge();
    check("seq_2A", {5'b0, q7}, 12'h02A);
    d7 = 7'h7F;
    next_edge();
    check("seq_7F", {5'b0, q7}, 12'h07F);

    // Asynchronous reset 5 ns after an edge.
    #3 reset = 1'b1;
    #1;
    check("async_mid_q7",  {5'b0, q7}, 12'h000);
    check("async_mid_q12", q12, 12'hA5A);
    d7 = 7'h3C;
    next_edge();
    check("async_hold_q7", {5'b0, q7}, 12'h000);

    // Reset priority at a coincident edge.
    reset = 1'b0;
    d7    = 7'h12;
    next_edge();
    check("pre_prio_q7", {5'b0, q7}, 12'h012);
    d7 = 7'h3C;
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("prio_q7", {5'b0, q7}, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    next_edge();
    check("post_prio_q7", {5'b0, q7}, 12'h03C);

    // Randomized phase: random data, mid-cycle glitches, reset pulses
    // that either clear between edges or straddle an edge.
    for (int i = 0; i < 300; i++) begin
      d7  = W7'($urandom);
      d12 = W12'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        #4 d7 = W7'($urandom);
        d12 = W12'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        #3 reset = 1'b1;
        #1;
        check("rand_async_q7",  {5'b0, q7}, 12'h000);
        check("rand_async_q12", q12, 12'hA5A);
        if ($urandom_range(0, 1) == 0) begin
          #4 reset = 1'b0;
        end else begin
          @(posedge clk);
          #5 reset = 1'b0;
        end
      end
      next_edge();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
